// File: rtl/cpu_core.sv
// cpu_core: 16-bit single-cycle Harvard load/store core that executes one instruction per CLK while in RUN.
// Instruction and data reads are combinational; a store raises dmem_write so the memory commits it at the next edge.
module cpu_core #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        CLK,
  input  logic        RSTN,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  output logic [15:0] dmem_addr,
  input  logic [15:0] dmem_rdata,
  output logic [15:0] dmem_wdata,
  output logic        dmem_write,
  input  logic        start,
  input  logic        stop
);

  localparam logic [0:0] MODE_IDLE = 1'b0;
  localparam logic [0:0] MODE_RUN  = 1'b1;

  localparam logic [3:0] OP_ALU  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_LHI  = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_BEQ  = 4'h6;
  localparam logic [3:0] OP_BNE  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JAL  = 4'h9;
  localparam logic [3:0] OP_JR   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [15:0] pc_q, pc_d;
  logic [0:0]  mode_q, mode_d;
  logic [15:0] regs_q [8];

  logic [3:0]  op;
  logic [2:0]  rd, rs, rt, fn;
  logic [15:0] rd_val, rs_val, rt_val;
  logic [15:0] imm6, imm9, imm12, pc_inc, ea, alu_res;
  logic        run, exec;

  logic        wb_en;
  logic [2:0]  wb_sel;
  logic [15:0] wb_dat;

  assign op    = imem_rdata[15:12];
  assign rd    = imem_rdata[11:9];
  assign rs    = imem_rdata[8:6];
  assign rt    = imem_rdata[5:3];
  assign fn    = imem_rdata[2:0];
  assign imm6  = {{10{imem_rdata[5]}}, imem_rdata[5:0]};
  assign imm9  = {{7{imem_rdata[8]}}, imem_rdata[8:0]};
  assign imm12 = {4'h0, imem_rdata[11:0]};

  // R0 is never written and resets to zero, so indexing it directly reads 0.
  assign rd_val = regs_q[rd];
  assign rs_val = regs_q[rs];
  assign rt_val = regs_q[rt];

  assign pc_inc = pc_q + 16'd1;
  assign ea     = rs_val + imm6;
  assign run    = (mode_q == MODE_RUN);
  assign exec   = run & ~stop;

  always_comb begin
    alu_res = 16'h0000;
    unique case (fn)
      3'd0: alu_res = rs_val + rt_val;
      3'd1: alu_res = rs_val - rt_val;
      3'd2: alu_res = rs_val & rt_val;
      3'd3: alu_res = rs_val | rt_val;
      3'd4: alu_res = rs_val ^ rt_val;
      3'd5: alu_res = {15'h0000, $signed(rs_val) < $signed(rt_val)};
      3'd6: alu_res = rs_val << rt_val[3:0];
      3'd7: alu_res = rs_val >> rt_val[3:0];
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    mode_d = mode_q;
    wb_en  = 1'b0;
    wb_sel = rd;
    wb_dat = alu_res;
    if (!run) begin
      if (start && !stop) mode_d = MODE_RUN;
    end else if (stop) begin
      mode_d = MODE_IDLE;
    end else begin
      pc_d = pc_inc;
      case (op)
        OP_ALU:  wb_en = 1'b1;
        OP_ADDI: begin wb_en = 1'b1; wb_dat = ea; end
        OP_LDI:  begin wb_en = 1'b1; wb_dat = imm9; end
        OP_LHI:  begin wb_en = 1'b1; wb_dat = {imem_rdata[7:0], rd_val[7:0]}; end
        OP_LD:   begin wb_en = 1'b1; wb_dat = dmem_rdata; end
        OP_BEQ:  if (rd_val == rs_val) pc_d = pc_inc + imm6;
        OP_BNE:  if (rd_val != rs_val) pc_d = pc_inc + imm6;
        OP_JMP:  pc_d = imm12;
        OP_JAL:  begin wb_en = 1'b1; wb_sel = 3'd7; wb_dat = pc_inc; pc_d = imm12; end
        OP_JR:   pc_d = rs_val;
        OP_HALT: mode_d = MODE_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RSTN) begin
      pc_q   <= RESET_PC;
      mode_q <= MODE_IDLE;
      for (int i = 0; i < 8; i++) regs_q[i] <= 16'h0000;
    end else begin
      pc_q   <= pc_d;
      mode_q <= mode_d;
      if (wb_en && (wb_sel != 3'd0)) regs_q[wb_sel] <= wb_dat;
    end
  end

  assign imem_addr  = pc_q;
  assign dmem_addr  = (run && (op == OP_LD || op == OP_ST)) ? ea : 16'h0000;
  assign dmem_wdata = (run && op == OP_ST) ? rd_val : 16'h0000;
  // A reset edge discards the in-flight instruction, so it must not commit a store either.
  assign dmem_write = exec & (op == OP_ST) & ~RSTN;

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: directed programs plus a random instruction stream, checked every cycle
// against an instruction-level interpreter of the ISA held in the bench.
module tb_cpu_core;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] imem_addr, imem_rdata, dmem_addr, dmem_rdata, dmem_wdata;
  logic        dmem_write;

  logic [15:0] imem [256];
  logic [15:0] dmem [256];

  assign imem_rdata = imem[imem_addr[7:0]];
  assign dmem_rdata = dmem[dmem_addr[7:0]];

  always #5 CLK = ~CLK;

  cpu_core #(.RESET_PC(16'h0000)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
    .dmem_wdata(dmem_wdata), .dmem_write(dmem_write),
    .start(start), .stop(stop)
  );

  logic [15:0] m_pc;
  logic [15:0] m_regs [8];
  logic [15:0] m_dmem [256];
  bit          m_run;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [15:0] rv(input logic [2:0] r);
    return (r == 3'd0) ? 16'h0000 : m_regs[r];
  endfunction

  function automatic logic [15:0] sx6(input logic [15:0] w);
    return {{10{w[5]}}, w[5:0]};
  endfunction

  task automatic setr(input logic [2:0] r, input logic [15:0] v);
    if (r != 3'd0) m_regs[r] = v;
  endtask

  // One clock edge of the architectural machine, given the inputs seen at that edge.
  task automatic model_edge(input bit rst, input bit st, input bit sp);
    logic [15:0] ins, a, b, d, npc, r, addr;
    if (rst) begin
      m_pc = 16'h0000; m_run = 1'b0;
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
      return;
    end
    if (!m_run) begin
      if (st && !sp) m_run = 1'b1;
      return;
    end
    if (sp) begin
      m_run = 1'b0;
      return;
    end
    ins  = imem[m_pc[7:0]];
    a    = rv(ins[8:6]);
    b    = rv(ins[5:3]);
    d    = rv(ins[11:9]);
    addr = a + sx6(ins);
    npc  = m_pc + 16'd1;
    r    = 16'h0000;
    case (ins[15:12])
      4'h0: begin
        case (ins[2:0])
          3'd0: r = a + b;
          3'd1: r = a - b;
          3'd2: r = a & b;
          3'd3: r = a | b;
          3'd4: r = a ^ b;
          3'd5: r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
          3'd6: r = a << b[3:0];
          default: r = a >> b[3:0];
        endcase
        setr(ins[11:9], r);
      end
      4'h1: setr(ins[11:9], addr);
      4'h2: setr(ins[11:9], {{7{ins[8]}}, ins[8:0]});
      4'h3: setr(ins[11:9], {ins[7:0], d[7:0]});
      4'h4: setr(ins[11:9], m_dmem[addr[7:0]]);
      4'h5: m_dmem[addr[7:0]] = d;
      4'h6: if (d == a) npc = m_pc + 16'd1 + sx6(ins);
      4'h7: if (d != a) npc = m_pc + 16'd1 + sx6(ins);
      4'h8: npc = {4'h0, ins[11:0]};
      4'h9: begin setr(3'd7, m_pc + 16'd1); npc = {4'h0, ins[11:0]}; end
      4'hA: npc = a;
      4'hF: m_run = 1'b0;
      default: ;
    endcase
    m_pc = npc;
  endtask

  // Drive one cycle, check all outputs mid-cycle, let the bench memory commit any store.
  task automatic step(input bit rst, input bit st, input bit sp);
    logic [15:0] ins, e_addr, e_wdat, wa, wd;
    bit          e_wr, w;
    RSTN = rst; start = st; stop = sp;
    @(negedge CLK);
    ins    = imem[m_pc[7:0]];
    e_addr = (m_run && (ins[15:12] == 4'h4 || ins[15:12] == 4'h5)) ? rv(ins[8:6]) + sx6(ins) : 16'h0000;
    e_wdat = (m_run && ins[15:12] == 4'h5) ? rv(ins[11:9]) : 16'h0000;
    e_wr   = m_run && (ins[15:12] == 4'h5) && !sp && !rst;
    chk("imem_addr", imem_addr, m_pc);
    chk("dmem_write", {15'h0000, dmem_write}, {15'h0000, e_wr});
    chk("dmem_addr", dmem_addr, e_addr);
    chk("dmem_wdata", dmem_wdata, e_wdat);
    w = dmem_write; wa = dmem_addr; wd = dmem_wdata;
    @(posedge CLK);
    #1;
    if (w) dmem[wa[7:0]] = wd;
    model_edge(rst, st, sp);
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'hB000; dmem[i] = 16'h0000; m_dmem[i] = 16'h0000;
    end
  endtask

  task automatic poke(input int a, input logic [15:0] v);
    dmem[a] = v; m_dmem[a] = v;
  endtask

  function automatic logic [15:0] alu(input logic [2:0] fn, input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
    return {4'h0, rd, rs, rt, fn};
  endfunction
  function automatic logic [15:0] ri(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs, input int imm);
    return {op, rd, rs, 6'(imm)};
  endfunction
  function automatic logic [15:0] ldi(input logic [2:0] rd, input int imm);
    return {4'h2, rd, 9'(imm)};
  endfunction
  function automatic logic [15:0] lhi(input logic [2:0] rd, input logic [7:0] b);
    return {4'h3, rd, 1'b0, b};
  endfunction
  function automatic logic [15:0] jop(input logic [3:0] op, input int imm);
    return {op, 12'(imm)};
  endfunction
  function automatic logic [15:0] jr(input logic [2:0] rs);
    return {4'hA, 3'd0, rs, 6'd0};
  endfunction

  localparam logic [15:0] HALT = 16'hF000;

  task automatic load_loop();
    clear_mem();
    imem[0] = ldi(3'd5, 0);
    imem[1] = ldi(3'd1, 10);
    imem[2] = alu(3'd0, 3'd5, 3'd5, 3'd1);
    imem[3] = ri(4'h1, 3'd1, 3'd1, -1);
    imem[4] = ri(4'h7, 3'd1, 3'd0, -3);
    imem[5] = ri(4'h5, 3'd5, 3'd0, 10);
    imem[6] = HALT;
  endtask

  logic [15:0] pc_hold;

  initial begin
    clear_mem();
    RSTN = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    model_edge(1'b1, 1'b0, 1'b0);

    // Reset held, then idle with start never asserted.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("idle_pc", imem_addr, 16'h0000);
      chk("idle_wr", {15'h0000, dmem_write}, 16'h0000);
    end

    // Arithmetic and store, then HALT.
    clear_mem();
    imem[0] = ldi(3'd1, 5);
    imem[1] = ldi(3'd2, -3);
    imem[2] = alu(3'd0, 3'd3, 3'd1, 3'd2);
    imem[3] = alu(3'd1, 3'd4, 3'd1, 3'd2);
    imem[4] = ri(4'h5, 3'd3, 3'd0, 0);
    imem[5] = ri(4'h5, 3'd4, 3'd0, 1);
    imem[6] = HALT;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    run_n(10);
    chk("arith_d0", dmem[0], 16'h0002);
    chk("arith_d1", dmem[1], 16'h0008);
    chk("arith_pc", imem_addr, 16'h0007);

    // Loop summing 1..10.
    load_loop();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    run_n(40);
    chk("loop_sum", dmem[10], 16'h0037);
    chk("loop_pc", imem_addr, 16'h0007);

    // Load, LHI and shifts.
    clear_mem();
    poke(3, 16'h00F0);
    imem[0] = ri(4'h4, 3'd1, 3'd0, 3);
    imem[1] = lhi(3'd1, 8'h12);
    imem[2] = ri(4'h5, 3'd1, 3'd0, 4);
    imem[3] = ldi(3'd2, 4);
    imem[4] = alu(3'd6, 3'd3, 3'd1, 3'd2);
    imem[5] = ri(4'h5, 3'd3, 3'd0, 5);
    imem[6] = alu(3'd7, 3'd4, 3'd1, 3'd2);
    imem[7] = ri(4'h5, 3'd4, 3'd0, 6);
    imem[8] = HALT;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    run_n(12);
    chk("lhi", dmem[4], 16'h12F0);
    chk("sll", dmem[5], 16'h2F00);
    chk("srl", dmem[6], 16'h012F);

    // Subroutine call and return.
    clear_mem();
    imem[0]     = jop(4'h9, 16'h10);
    imem[1]     = ri(4'h5, 3'd1, 3'd0, 0);
    imem[2]     = ri(4'h5, 3'd7, 3'd0, 1);
    imem[3]     = HALT;
    imem[8'h10] = ldi(3'd1, 7);
    imem[8'h11] = jr(3'd7);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    run_n(9);
    chk("jal_r1", dmem[0], 16'h0007);
    chk("jal_r7", dmem[1], 16'h0001);
    chk("jal_pc", imem_addr, 16'h0004);

    // PC wraps from 0xFFFF to 0x0000.
    clear_mem();
    imem[0]    = ldi(3'd1, -1);
    imem[1]    = jr(3'd1);
    imem[8'hFF] = HALT;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    run_n(2);
    chk("wrap_top", imem_addr, 16'hFFFF);
    run_n(1);
    chk("wrap_zero", imem_addr, 16'h0000);

    // Stop mid-loop freezes the core; resume finishes with the same result.
    load_loop();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    run_n(12);
    pc_hold = m_pc;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1);
      chk("stop_pc", imem_addr, pc_hold);
    end
    step(1'b0, 1'b1, 1'b0);
    run_n(40);
    chk("resume_sum", dmem[10], 16'h0037);

    // Reset mid-run clears PC and every register.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    run_n(8);
    step(1'b1, 1'b0, 1'b0);
    chk("rst_pc", imem_addr, 16'h0000);
    clear_mem();
    for (int i = 1; i < 8; i++) begin
      imem[i - 1] = ri(4'h5, 3'(i), 3'd0, 20 + i);
      poke(20 + i, 16'hAAAA);
    end
    imem[7] = HALT;
    step(1'b0, 1'b1, 1'b0);
    run_n(10);
    for (int i = 1; i < 8; i++) chk("rst_reg", dmem[20 + i], 16'h0000);

    // Reset landing on a store cycle must not write memory.
    clear_mem();
    imem[0] = ldi(3'd1, 9);
    imem[1] = ri(4'h5, 3'd1, 3'd0, 30);
    imem[2] = jop(4'h8, 1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("rst_nowrite", dmem[30], 16'h0000);

    // Random instruction stream with random start/stop/reset.
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'($urandom);
      poke(i, 16'($urandom));
    end
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 10);
    end
    for (int i = 0; i < 256; i++) chk("rand_dmem", dmem[i], m_dmem[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
